counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, the counter width in bits.
REQ-002 The block SHALL have parameter DEFAULT_MAX, default 12'd15, the terminal count after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port start, input, 1 bit: begin counting, or resume from pause.
REQ-006 The block SHALL have port pause, input, 1 bit: freeze an active count.
REQ-007 The block SHALL have port clear, input, 1 bit: abort and return to idle.
REQ-008 The block SHALL have port step, input, 1 bit: count-enable tick (prescaler strobe).
REQ-009 The block SHALL have port load_max, input, 1 bit: capture max_in as the terminal count.
REQ-010 The block SHALL have port max_in, input, WIDTH bits: new terminal count value.
REQ-011 The block SHALL have port count, output, WIDTH bits: current count value (registered).
REQ-012 The block SHALL have port state, output, 2 bits, with encoding IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-013 The block SHALL have port busy, output, 1 bit: high in RUN or PAUSE; combinational from state.
REQ-014 The block SHALL have port done, output, 1 bit: registered one-cycle terminal-count pulse.

Function
REQ-015 The control-input priority SHALL be clear > start > pause; lower-priority inputs are ignored in any cycle where a higher-priority one is taken.
REQ-016 On clear in any state, the block SHALL go to IDLE next edge with count=0 and done=0.
REQ-017 In IDLE, count SHALL be held at 0; start SHALL move to RUN with count still 0.
REQ-018 In IDLE only, load_max SHALL copy max_in into max_reg; load_max SHALL be ignored in RUN/PAUSE/DONE; load_max together with start in IDLE SHALL load and start in the same edge.
REQ-019 In RUN with step=1 and count<max_reg, count SHALL increment by 1; with step=0, count SHALL hold.
REQ-020 In RUN with step=1 and count==max_reg, done SHALL be 1 for exactly the next cycle, and the count and state SHALL follow REQ-029/REQ-030.
REQ-021 In RUN, pause (without clear/start) SHALL move to PAUSE with count held; a step in the same cycle SHALL be discarded.
REQ-022 In PAUSE, count SHALL hold regardless of step; start SHALL return to RUN; pause SHALL be ignored.
REQ-023 In DONE, count SHALL hold max_reg; start SHALL move to RUN with count=0; step and pause SHALL be ignored.
REQ-024 With max_reg=0, the first step in RUN SHALL produce done and terminal behaviour; count never exceeds 0.
REQ-025 Arithmetic SHALL be unsigned WIDTH-bit; count SHALL never exceed max_reg, so no overflow wrap occurs.

Reset
REQ-026 When reset=0, the block SHALL immediately set state=IDLE, count=0, done=0, and max_reg=DEFAULT_MAX, independent of clk.
REQ-027 Reset asserted mid-RUN or mid-PAUSE SHALL abort without a done pulse; operation SHALL resume from IDLE on the first rising edge after reset=1.
REQ-028 After release, all outputs SHALL remain at their reset values until an input acts.

Configuration
REQ-029 Macro COUNTER_CTRL_AUTORELOAD_EN defined: on terminal step, count SHALL go to 0, the state SHALL remain RUN, and done SHALL pulse every period.
REQ-030 Macro COUNTER_CTRL_AUTORELOAD_EN undefined: on terminal step, state SHALL go to DONE with count held at max_reg, and the DONE state SHALL be held until start or clear.

Verification
REQ-031 Reset release, load_max=1 with max_in=5 in IDLE, start, step held 1 -> count 0,1,2,3,4,5; done=1 for one cycle; state=DONE with count=5 (non-autoreload).
REQ-032 DEFAULT_MAX=15, start, step=1 for 8 cycles, pause for 5 cycles with step=1, start, further steps -> count holds at 8 during PAUSE and busy=1; counting then resumes 9..15.
REQ-033 clear, start, and pause all high together during RUN at count=7 -> state=IDLE, count=0, no done pulse.
REQ-034 reset driven low mid-RUN at count=10, between clock edges -> count=0 and state=IDLE immediately; max_reg=15.
REQ-035 load_max with max_in=3 while in RUN -> ignored; terminal count SHALL remain at the prior value.
REQ-036 With COUNTER_CTRL_AUTORELOAD_EN defined, max=2, step=1 continuously -> count 0,1,2,0,1,2...; done pulses every 3 cycles; state SHALL stay RUN.

Source files
------------

// File: rtl/counter_ctrl_if.sv
// Control/status bundle for counter_ctrl: command strobes and terminal-count load in,
// count/state/busy/done out.
interface counter_ctrl_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic             pause;
  logic             clear;
  logic             step;
  logic             load_max;
  logic [WIDTH-1:0] max_in;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             busy;
  logic             done;

  modport master (
    output start, pause, clear, step, load_max, max_in,
    input  count, state, busy, done
  );

  modport slave (
    input  start, pause, clear, step, load_max, max_in,
    output count, state, busy, done
  );
endinterface

// File: rtl/counter_ctrl.sv
// Start/pause/clear controlled up-counter with a loadable terminal count and a done pulse.
// Define COUNTER_CTRL_AUTORELOAD_EN to wrap to 0 and keep running at terminal count.
module counter_ctrl #(
  parameter int               WIDTH       = 12,
  parameter logic [WIDTH-1:0] DEFAULT_MAX = WIDTH'(15)
) (
  input  logic          clk,
  input  logic          reset,
  counter_ctrl_if.slave bus
);

  // state | meaning
  // IDLE  | count held at 0, terminal count may be loaded
  // RUN   | count advances on each step until terminal
  // PAUSE | count frozen, start resumes
  // DONE  | terminal reached, count held at max until start/clear
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      max_q   <= DEFAULT_MAX;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      max_q   <= max_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    max_d   = max_q;
    done_d  = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
          if (bus.load_max) max_d = bus.max_in;
          if (bus.start) state_d = RUN;
        end
        RUN: begin
          if (!bus.start && bus.pause) begin
            state_d = PAUSE;
          end else if (bus.step) begin
            // max cannot change outside IDLE, so >= is equality in practice
            if (count_q >= max_q) begin
              done_d = 1'b1;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
              count_d = '0;
`else
              state_d = DONE;
              count_d = max_q;
`endif
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        PAUSE: begin
          if (bus.start) state_d = RUN;
        end
        DONE: begin
          if (bus.start) begin
            state_d = RUN;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.state = state_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q == RUN) || (state_q == PAUSE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Vector/scoreboard bench for counter_ctrl; expectations follow the autoreload macro setting.
module tb_counter_ctrl;

`ifdef COUNTER_CTRL_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_ST   = 5'b10000;
  localparam logic [4:0] C_PA   = 5'b01000;
  localparam logic [4:0] C_CL   = 5'b00100;
  localparam logic [4:0] C_SP   = 5'b00010;
  localparam logic [4:0] C_LD   = 5'b00001;

  typedef struct {
    string       name;
    logic [4:0]  ctl;
    logic [11:0] max_in;
    logic [11:0] e_count;
    logic [1:0]  e_state;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  vec_t tbl[$];
  vec_t exp_q[$];

  counter_ctrl_if #(.WIDTH(12)) bus ();

  counter_ctrl #(.WIDTH(12), .DEFAULT_MAX(12'd15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(string nm, logic [4:0] ctl, int mx, int ec, int es, bit eb, bit ed);
    vec_t v;
    v.name    = nm;
    v.ctl     = ctl;
    v.max_in  = 12'(mx);
    v.e_count = 12'(ec);
    v.e_state = 2'(es);
    v.e_busy  = eb;
    v.e_done  = ed;
    return v;
  endfunction

  task automatic check_now();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      if (bus.count !== e.e_count || bus.state !== e.e_state ||
          bus.busy !== e.e_busy || bus.done !== e.e_done) begin
        n_bad++;
        $display("FAIL %s: got count=%0d state=%0d busy=%b done=%b, want count=%0d state=%0d busy=%b done=%b",
                 e.name, bus.count, bus.state, bus.busy, bus.done,
                 e.e_count, e.e_state, e.e_busy, e.e_done);
      end
    end
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    {bus.start, bus.pause, bus.clear, bus.step, bus.load_max} = v.ctl;
    bus.max_in = v.max_in;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    {bus.start, bus.pause, bus.clear, bus.step, bus.load_max} = C_NONE;
    bus.max_in = '0;

    // table: basic count, terminal, load ignored in RUN, priorities, pause, max=0
    tbl.push_back(mk("idle_after_rst", C_NONE, 0, 0, 0, 0, 0));
    tbl.push_back(mk("load5", C_LD, 5, 0, 0, 0, 0));
    tbl.push_back(mk("start", C_ST, 0, 0, 1, 1, 0));
    for (int i = 1; i <= 5; i++) tbl.push_back(mk("count_to5", C_SP, 0, i, 1, 1, 0));
    tbl.push_back(mk("term5", C_SP, 0, AR ? 0 : 5, AR ? 1 : 3, AR, 1));
    tbl.push_back(mk("after_term5", C_SP, 0, AR ? 1 : 5, AR ? 1 : 3, AR, 0));
    tbl.push_back(mk("clear1", C_CL, 0, 0, 0, 0, 0));
    tbl.push_back(mk("start2", C_ST, 0, 0, 1, 1, 0));
    tbl.push_back(mk("load_in_run", C_LD | C_SP, 3, 1, 1, 1, 0));
    for (int i = 2; i <= 5; i++) tbl.push_back(mk("count_past3", C_SP, 0, i, 1, 1, 0));
    tbl.push_back(mk("term_still5", C_SP, 0, AR ? 0 : 5, AR ? 1 : 3, AR, 1));
    tbl.push_back(mk("clear2", C_CL, 0, 0, 0, 0, 0));
    tbl.push_back(mk("load_and_start", C_ST | C_LD, 9, 0, 1, 1, 0));
    for (int i = 1; i <= 7; i++) tbl.push_back(mk("count_to7", C_SP, 0, i, 1, 1, 0));
    tbl.push_back(mk("clear_start_pause", C_CL | C_ST | C_PA | C_SP, 0, 0, 0, 0, 0));
    tbl.push_back(mk("idle_step", C_SP, 0, 0, 0, 0, 0));
    tbl.push_back(mk("start3", C_ST, 0, 0, 1, 1, 0));
    tbl.push_back(mk("step1", C_SP, 0, 1, 1, 1, 0));
    tbl.push_back(mk("pause_drops_step", C_PA | C_SP, 0, 1, 2, 1, 0));
    tbl.push_back(mk("paused_step", C_SP, 0, 1, 2, 1, 0));
    tbl.push_back(mk("paused_pause", C_PA, 0, 1, 2, 1, 0));
    tbl.push_back(mk("resume_over_pause", C_ST | C_PA | C_SP, 0, 1, 1, 1, 0));
    tbl.push_back(mk("step2", C_SP, 0, 2, 1, 1, 0));
    tbl.push_back(mk("clear3", C_CL, 0, 0, 0, 0, 0));
    tbl.push_back(mk("load0", C_LD, 0, 0, 0, 0, 0));
    tbl.push_back(mk("start_max0", C_ST, 0, 0, 1, 1, 0));
    tbl.push_back(mk("term_max0", C_SP, 0, 0, AR ? 1 : 3, AR, 1));
    tbl.push_back(mk("again_max0", C_SP, 0, 0, AR ? 1 : 3, AR, AR));
    tbl.push_back(mk("restart_max0", C_ST, 0, 0, 1, 1, 0));
    tbl.push_back(mk("clear4", C_CL, 0, 0, 0, 0, 0));

    #3;
    exp_q.push_back(mk("in_reset", C_NONE, 0, 0, 0, 0, 0));
    check_now();
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // asynchronous reset mid-RUN at count 10
    apply(mk("load12", C_LD, 12, 0, 0, 0, 0));
    apply(mk("start_r", C_ST, 0, 0, 1, 1, 0));
    for (int i = 1; i <= 10; i++) apply(mk("count_to10", C_SP, 0, i, 1, 1, 0));
    @(negedge clk);
    #2;
    reset = 1'b0;
    exp_q.push_back(mk("async_reset", C_SP, 0, 0, 0, 0, 0));
    #1;
    check_now();
    @(posedge clk);
    #1;
    exp_q.push_back(mk("held_in_reset", C_SP, 0, 0, 0, 0, 0));
    check_now();
    @(negedge clk);
    reset = 1'b1;
    {bus.start, bus.pause, bus.clear, bus.step, bus.load_max} = C_NONE;
    apply(mk("idle_after_release", C_NONE, 0, 0, 0, 0, 0));
    apply(mk("idle_quiet", C_NONE, 0, 0, 0, 0, 0));

    // default max of 15 restored; pause for 5 cycles at count 8
    apply(mk("start_p", C_ST, 0, 0, 1, 1, 0));
    for (int i = 1; i <= 8; i++) apply(mk("count_to8", C_SP, 0, i, 1, 1, 0));
    for (int i = 0; i < 5; i++) apply(mk("pause_hold8", C_PA | C_SP, 0, 8, 2, 1, 0));
    apply(mk("resume8", C_ST, 0, 8, 1, 1, 0));
    for (int i = 9; i <= 15; i++) apply(mk("count_to15", C_SP, 0, i, 1, 1, 0));
    apply(mk("term15", C_SP, 0, AR ? 0 : 15, AR ? 1 : 3, AR, 1));

`ifdef COUNTER_CTRL_AUTORELOAD_EN
    apply(mk("clear_ar", C_CL, 0, 0, 0, 0, 0));
    apply(mk("load2", C_LD, 2, 0, 0, 0, 0));
    apply(mk("start_ar", C_ST, 0, 0, 1, 1, 0));
    for (int i = 0; i < 9; i++) apply(mk("reload_cycle", C_SP, 0, (i + 1) % 3, 1, 1, (i % 3) == 2));
`else
    apply(mk("done_hold", C_SP | C_PA, 0, 15, 3, 0, 0));
    apply(mk("done_restart", C_ST, 0, 0, 1, 1, 0));
    apply(mk("restart_step", C_SP, 0, 1, 1, 1, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
